motor_cfg_sequencer: RTL and testbench

- AXI4-Lite master that programs the motor peripheral's register bank from a parallel configuration vector.
- Each start pulse triggers a burst of single-beat writes to consecutive 32-bit registers from BASE_ADDR.
- Sits between the motor control logic (or PS GPIO) and the motor AXI4-Lite slave, replacing manual register pokes.
- Reports completion and the first error (bad response or readback mismatch).

---
 rtl/motor_cfg_sequencer_if.sv | 56 +++++
 rtl/motor_cfg_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_motor_cfg_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_cfg_sequencer_if.sv
// AXI4-Lite master-side bundle for motor_cfg_sequencer.
// Carries the five AXI4-Lite channels. The master modport faces the
// sequencer and the slave modport faces the motor register bank.
interface motor_cfg_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic [2:0]        M_AXI_AWPROT;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;

  logic [31:0]       M_AXI_WDATA;
  logic [3:0]        M_AXI_WSTRB;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;

  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;

  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;

  logic [31:0]       M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/motor_cfg_sequencer.sv
// motor_cfg_sequencer: AXI4-Lite master that writes NUM_REGS consecutive
// 32-bit registers from BASE_ADDR with the values in cfg_data. Each sequence
// is started by one pulse on start.
// Only one transaction is outstanding at any time. The sequencer reports
// done, and it records the first error in err/err_code/err_idx.
// Optional macro READBACK_VERIFY_EN: each write is followed by a read of the
// same address. The read data must match the value that was written.
module motor_cfg_sequencer #(
  parameter int          NUM_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [NUM_REGS*32-1:0] cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [3:0]            err_idx,
  motor_cfg_sequencer_if.master m_axi
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
`ifdef READBACK_VERIFY_EN
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
`endif
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);

  localparam logic [1:0] ERR_BRESP = 2'b01;
`ifdef READBACK_VERIFY_EN
  localparam logic [1:0] ERR_RRESP = 2'b10;
  localparam logic [1:0] ERR_MISM  = 2'b11;
`endif

  logic [2:0]              state;
  logic [3:0]              idx;
  logic [3:0]              idx_nxt;
  logic [NUM_REGS*32-1:0]  shadow;

  logic [ADDR_W-1:0]       awaddr_q;
  logic                    awvalid_q;
  logic [31:0]             wdata_q;
  logic                    wvalid_q;
  logic                    bready_q;

  logic                    aw_done;
  logic                    w_done;

  assign idx_nxt = idx + 4'd1;

  // A channel counts as complete once its VALID has gone low, or when it is handshaking in this cycle.
  assign aw_done = !awvalid_q || m_axi.M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || m_axi.M_AXI_WREADY;

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;

`ifdef READBACK_VERIFY_EN
  logic [ADDR_W-1:0]       araddr_q;
  logic                    arvalid_q;
  logic                    rready_q;

  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
`else
  logic                    unused_rd;

  assign m_axi.M_AXI_ARADDR  = '0;
  assign m_axi.M_AXI_ARVALID = 1'b0;
  assign m_axi.M_AXI_RREADY  = 1'b0;
  assign unused_rd = ^{m_axi.M_AXI_ARREADY, m_axi.M_AXI_RDATA,
                       m_axi.M_AXI_RRESP, m_axi.M_AXI_RVALID};
`endif

  // Sequencer FSM: issues one write at a time, optionally reads it back, and records the first error.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      idx       <= '0;
      shadow    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      err_idx   <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
`ifdef READBACK_VERIFY_EN
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow    <= cfg_data;
            idx       <= '0;
            err       <= 1'b0;
            err_code  <= '0;
            err_idx   <= '0;
            busy      <= 1'b1;
            awaddr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q   <= cfg_data[31:0];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= S_WR;
          end
        end

        S_WR: begin
          if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            bready_q <= 1'b0;
            if (m_axi.M_AXI_BRESP != 2'b00) begin
              err      <= 1'b1;
              err_code <= ERR_BRESP;
              err_idx  <= idx;
              state    <= S_FIN;
            end else begin
`ifdef READBACK_VERIFY_EN
              araddr_q  <= awaddr_q;
              arvalid_q <= 1'b1;
              state     <= S_RD_ADDR;
`else
              state     <= S_NEXT;
`endif
            end
          end
        end

`ifdef READBACK_VERIFY_EN
        S_RD_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end

        // wdata_q still holds shadow[idx], so it is the reference value for the readback.
        S_RD_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            rready_q <= 1'b0;
            if (m_axi.M_AXI_RRESP != 2'b00) begin
              err      <= 1'b1;
              err_code <= ERR_RRESP;
              err_idx  <= idx;
              state    <= S_FIN;
            end else if (m_axi.M_AXI_RDATA != wdata_q) begin
              err      <= 1'b1;
              err_code <= ERR_MISM;
              err_idx  <= idx;
              state    <= S_FIN;
            end else begin
              state    <= S_NEXT;
            end
          end
        end
`endif

        S_NEXT: begin
          if (idx == LAST_IDX) begin
            state <= S_FIN;
          end else begin
            idx       <= idx_nxt;
            awaddr_q  <= awaddr_q + ADDR_W'(4);
            wdata_q   <= shadow[32*int'(idx_nxt) +: 32];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= S_WR;
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cfg_sequencer.sv
// Self-checking bench for motor_cfg_sequencer, with an AXI4-Lite slave model
// whose AW/W/B delays can be programmed.
// Expected writes are queued when a sequence starts. The slave pops and
// compares one entry for each completed write.
module tb_motor_cfg_sequencer;

  localparam int NREG = 4;

  logic             tb_ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic             start   = 1'b0;
  logic [NREG*32-1:0] cfg_data = '0;
  logic             busy, done, err;
  logic [1:0]       err_code;
  logic [3:0]       err_idx;

  motor_cfg_sequencer_if #(.ADDR_W(32)) axi ();

  motor_cfg_sequencer #(
    .NUM_REGS (NREG),
    .BASE_ADDR(32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .ACLK    (tb_ACLK),
    .ARESETN (ARESETN),
    .start   (start),
    .cfg_data(cfg_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_code(err_code),
    .err_idx (err_idx),
    .m_axi   (axi.master)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  int          err_reg  = -1;
  bit          ro_bit31 = 1'b0;
  int          wr_count = 0;
  int          done_cnt = 0;
  bit          ar_seen  = 1'b0;

  logic [31:0] mem [16];
  logic [31:0] cap_aw, cap_w, last_wr_addr, pend_aw_addr, pend_w_data;
  bit          aw_got, w_got, b_pend, pend_aw, pend_w;
  int          aw_cnt, w_cnt, b_cnt;
  logic [3:0]  b_idx;

  // AXI4-Lite slave model: programmable delays, scoreboard check on each write, optional read-only bit 31 on register 1.
  always @(posedge tb_ACLK or negedge ARESETN) begin : slave
    bit ag, wg;
    logic [31:0] a, d;
    wr_t e;
    if (!ARESETN) begin
      axi.M_AXI_AWREADY <= 1'b1;
      axi.M_AXI_WREADY  <= 1'b1;
      axi.M_AXI_BVALID  <= 1'b0;
      axi.M_AXI_BRESP   <= 2'b00;
      axi.M_AXI_ARREADY <= 1'b1;
      axi.M_AXI_RVALID  <= 1'b0;
      axi.M_AXI_RDATA   <= '0;
      axi.M_AXI_RRESP   <= 2'b00;
      aw_got <= 0; w_got <= 0; b_pend <= 0; pend_aw <= 0; pend_w <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      ag = aw_got; wg = w_got; a = cap_aw; d = cap_w;

      if (pend_aw) begin
        check("awvalid_held", axi.M_AXI_AWVALID, 1);
        check("awaddr_stable", axi.M_AXI_AWADDR, pend_aw_addr);
      end
      if (pend_w) begin
        check("wvalid_held", axi.M_AXI_WVALID, 1);
        check("wdata_stable", axi.M_AXI_WDATA, pend_w_data);
      end
      if (aw_got && axi.M_AXI_AWVALID) check("awvalid_after_hs", 1, 0);
      if (w_got && axi.M_AXI_WVALID)   check("wvalid_after_hs", 1, 0);
      pend_aw      <= axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY;
      pend_aw_addr <= axi.M_AXI_AWADDR;
      pend_w       <= axi.M_AXI_WVALID && !axi.M_AXI_WREADY;
      pend_w_data  <= axi.M_AXI_WDATA;

      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        if (ag) check("aw_dup", 1, 0);
        ag = 1; a = axi.M_AXI_AWADDR;
        aw_cnt <= 0;
        axi.M_AXI_AWREADY <= (aw_delay == 0);
      end else if (axi.M_AXI_AWVALID) begin
        aw_cnt <= aw_cnt + 1;
        if (aw_cnt + 1 >= aw_delay) axi.M_AXI_AWREADY <= 1'b1;
      end else begin
        aw_cnt <= 0;
        axi.M_AXI_AWREADY <= (aw_delay == 0);
      end

      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        if (wg) check("w_dup", 1, 0);
        wg = 1; d = axi.M_AXI_WDATA;
        w_cnt <= 0;
        axi.M_AXI_WREADY <= (w_delay == 0);
      end else if (axi.M_AXI_WVALID) begin
        w_cnt <= w_cnt + 1;
        if (w_cnt + 1 >= w_delay) axi.M_AXI_WREADY <= 1'b1;
      end else begin
        w_cnt <= 0;
        axi.M_AXI_WREADY <= (w_delay == 0);
      end

      if (ag && wg) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", {32'h0, a}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", a, e.addr);
          check("wr_data", d, e.data);
        end
        mem[a[5:2]]  <= (ro_bit31 && a[5:2] == 4'd1) ? (d & 32'h7FFF_FFFF) : d;
        last_wr_addr <= a;
        b_idx  <= a[5:2];
        b_pend <= 1'b1;
        b_cnt  <= 0;
        wr_count <= wr_count + 1;
        ag = 0; wg = 0;
      end
      aw_got <= ag; w_got <= wg; cap_aw <= a; cap_w <= d;

      if (b_pend) begin
        if (b_cnt >= b_delay) begin
          axi.M_AXI_BVALID <= 1'b1;
          axi.M_AXI_BRESP  <= (int'(b_idx) == err_reg) ? 2'b10 : 2'b00;
          b_pend <= 1'b0;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) axi.M_AXI_BVALID <= 1'b0;

      if (axi.M_AXI_ARVALID) begin
        ar_seen <= 1'b1;
        if (b_pend || axi.M_AXI_BVALID || axi.M_AXI_AWVALID || axi.M_AXI_WVALID)
          check("rd_wr_overlap", 1, 0);
      end
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        check("ar_addr", axi.M_AXI_ARADDR, last_wr_addr);
        axi.M_AXI_RDATA  <= mem[axi.M_AXI_ARADDR[5:2]];
        axi.M_AXI_RRESP  <= 2'b00;
        axi.M_AXI_RVALID <= 1'b1;
      end
      if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) axi.M_AXI_RVALID <= 1'b0;
    end
  end

  // Count done pulses so that the bench can require exactly one pulse per sequence.
  always @(posedge tb_ACLK) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic push_exp(input logic [NREG*32-1:0] cfg, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: 32'(4 * i), data: cfg[32*i +: 32]});
  endtask

  task automatic pulse_start(input logic [NREG*32-1:0] cfg);
    @(negedge tb_ACLK);
    cfg_data = cfg;
    start    = 1'b1;
    @(negedge tb_ACLK);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int  n = 0;
    bit  seen = 0, busy_ok = 1;
    int  d0 = done_cnt;
    while (!seen && n < 2000) begin
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busy_ok = 0;
      if (!seen) begin
        @(negedge tb_ACLK);
        n++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_during"}, busy_ok, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    repeat (4) @(negedge tb_ACLK);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  localparam logic [NREG*32-1:0] CFG_A = {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF};
  localparam logic [NREG*32-1:0] CFG_B = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w0;
    // reset state
    repeat (3) @(negedge tb_ACLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code, err_idx}, 0);
    check("rst_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                         axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 0);
    check("rst_addr_data", {axi.M_AXI_AWADDR, axi.M_AXI_WDATA}, 0);
    check("awprot", axi.M_AXI_AWPROT, 0);
    check("wstrb", axi.M_AXI_WSTRB, 4'hF);
    ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);

    // zero-wait slave, full sequence
    w0 = wr_count;
    push_exp(CFG_A, 4);
    pulse_start(CFG_A);
    check("t1_busy_start", busy, 1);
    wait_done("t1");
    check("t1_err", {err, err_code}, 0);
    check("t1_writes", wr_count - w0, 4);
    check("t1_q_empty", exp_q.size(), 0);

    // AWREADY delayed, WREADY immediate
    aw_delay = 3; w_delay = 0;
    w0 = wr_count;
    push_exp(CFG_B, 4);
    pulse_start(CFG_B);
    wait_done("t2a");
    check("t2a_writes", wr_count - w0, 4);
    check("t2a_q_empty", exp_q.size(), 0);

    // WREADY delayed, AWREADY immediate
    aw_delay = 0; w_delay = 3;
    w0 = wr_count;
    push_exp(CFG_A, 4);
    pulse_start(CFG_A);
    wait_done("t2b");
    check("t2b_writes", wr_count - w0, 4);
    check("t2b_q_empty", exp_q.size(), 0);
    w_delay = 0;

    // BRESP error on register 2
    err_reg = 2;
    w0 = wr_count;
    push_exp(CFG_B, 3);
    pulse_start(CFG_B);
    wait_done("t3");
    check("t3_err", err, 1);
    check("t3_err_code", err_code, 2'b01);
    check("t3_err_idx", err_idx, 4'd2);
    check("t3_writes", wr_count - w0, 3);
    check("t3_q_empty", exp_q.size(), 0);
    err_reg = -1;

    // start re-pulsed and cfg_data changed mid-sequence; also err cleared by new start
    w0 = wr_count;
    push_exp(CFG_A, 4);
    pulse_start(CFG_A);
    check("t5_err_cleared", {err, err_code, err_idx}, 0);
    repeat (3) @(negedge tb_ACLK);
    cfg_data = CFG_B;
    start = 1'b1;
    @(negedge tb_ACLK);
    start = 1'b0;
    wait_done("t5");
    repeat (20) @(negedge tb_ACLK);
    check("t5_writes", wr_count - w0, 4);
    check("t5_q_empty", exp_q.size(), 0);
    check("t5_idle", busy, 0);

`ifdef READBACK_VERIFY_EN
    // readback mismatch on register 1 (bit 31 read-only 0)
    ro_bit31 = 1'b1;
    push_exp({32'h0000_0003, 32'h0000_0002, 32'h8000_0001, 32'hABCD_0001}, 2);
    pulse_start({32'h0000_0003, 32'h0000_0002, 32'h8000_0001, 32'hABCD_0001});
    wait_done("t4a");
    check("t4a_err", err, 1);
    check("t4a_err_code", err_code, 2'b11);
    check("t4a_err_idx", err_idx, 4'd1);
    check("t4a_q_empty", exp_q.size(), 0);
    push_exp({32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'hABCD_0001}, 4);
    pulse_start({32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'hABCD_0001});
    wait_done("t4b");
    check("t4b_err", {err, err_code}, 0);
    check("t4b_q_empty", exp_q.size(), 0);
    check("t4b_ar_seen", ar_seen, 1);
    ro_bit31 = 1'b0;
`else
    check("no_read_channel", ar_seen, 0);
    check("araddr_tied", axi.M_AXI_ARADDR, 0);
`endif

    // asynchronous reset during WR_RESP of register 1
    b_delay = 6;
    w0 = wr_count;
    push_exp(CFG_A, 4);
    pulse_start(CFG_A);
    begin
      int n = 0;
      while (!(wr_count - w0 == 2 && axi.M_AXI_BREADY === 1'b1) && n < 200) begin
        @(negedge tb_ACLK);
        n++;
      end
      check("t6_reached_wr_resp1", n < 200, 1);
    end
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_async_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                              axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 0);
    check("t6_async_busy", {busy, done}, 0);
    exp_q.delete();
    b_delay = 0;
    @(negedge tb_ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    w0 = wr_count;
    push_exp(CFG_B, 4);
    pulse_start(CFG_B);
    wait_done("t6");
    check("t6_err", {err, err_code}, 0);
    check("t6_writes", wr_count - w0, 4);
    check("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
